// File: rtl/i2s_frame_bridge.sv
// i2s_frame_bridge: elastic, frame-aligned sample buffer between the
// I2S RX and TX codecs, with priming, overflow drop and underrun policy.
module i2s_frame_bridge #(
    parameter int DATA_WIDTH    = 24,
    parameter int NUM_CH        = 2,
    parameter int DEPTH_FRAMES  = 8,
    parameter int PRIME_FRAMES  = 2,
    parameter int UNDERRUN_HOLD = 0,
    localparam int LW = $clog2(DEPTH_FRAMES * NUM_CH) + 1
) (
    input  logic          lmmi_clk_i,
    input  logic          reset_n_i,
    input  logic          en_i,
    input  logic          rx_valid_i,
    input  logic [31:0]   rx_data_i,
    input  logic          tx_req_i,
    output logic [31:0]   tx_data_o,
    input  logic          clear_i,
    output logic [LW-1:0] level_o,
    output logic          running_o,
    output logic          overflow_o,
    output logic          underrun_o
);

    localparam int S         = DEPTH_FRAMES * NUM_CH;
    localparam int AW        = $clog2(S);
    localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PRIME_LVL = PRIME_FRAMES * NUM_CH;

    typedef enum logic {
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH:0] mem [S];
    logic [AW-1:0]       wr_ptr, rd_ptr, rd_nxt;
    logic [LW-1:0]       level, lvl_after_pop, lvl_nxt;
    logic [CW-1:0]       rx_ch, tx_ch;
    logic                frame_acc;
    logic                pop, we, accept, drop_ev, underrun_ev;
    logic                empty, rx_first, rx_last, tx_last;
    logic [DATA_WIDTH:0] head, head_nxt, wentry;
    logic [31:0]         tx_nxt;
    logic                unused_rx;

    assign unused_rx = ^rx_data_i;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(S - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [31:0] sext(input logic [DATA_WIDTH-1:0] s);
        return 32'($signed(s));
    endfunction

    assign head      = mem[rd_ptr];
    assign empty     = (level == '0);
    assign rx_first  = (rx_ch == '0);
    assign rx_last   = (rx_ch == CW'(NUM_CH - 1));
    assign tx_last   = (tx_ch == CW'(NUM_CH - 1));
    assign wentry    = {rx_first, rx_data_i[DATA_WIDTH-1:0]};
    assign level_o   = level;
    assign running_o = (state == ST_RUN);

    // Next state, pop/write decisions and the prefetched TX register value.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        underrun_ev = 1'b0;
        unique case (state)
            ST_PRIME: begin
                pop = !empty && !head[DATA_WIDTH];
                if (!empty && head[DATA_WIDTH] &&
                    level >= LW'(PRIME_LVL) &&
                    ((tx_req_i && tx_last) ||
                     (!tx_req_i && tx_ch == '0)))
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (tx_req_i) begin
                    if (empty) begin
                        underrun_ev = 1'b1;
                        state_nxt   = ST_PRIME;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_PRIME;
        endcase

        lvl_after_pop = level - LW'(pop);
        accept        = (lvl_after_pop <= LW'(S - NUM_CH));
        we            = rx_valid_i && (rx_first ? accept : frame_acc);
        drop_ev       = rx_valid_i && rx_first && !accept;
        rd_nxt        = pop ? inc(rd_ptr) : rd_ptr;
        lvl_nxt       = level + LW'(we) - LW'(pop);
        head_nxt      = (we && lvl_after_pop == '0) ? wentry : mem[rd_nxt];

        tx_nxt = tx_data_o;
        if (state_nxt == ST_RUN) begin
            if (lvl_nxt != '0)
                tx_nxt = sext(head_nxt[DATA_WIDTH-1:0]);
            else if (UNDERRUN_HOLD == 0)
                tx_nxt = '0;
        end else if (underrun_ev && UNDERRUN_HOLD == 0) begin
            tx_nxt = '0;
        end
    end

    // Sample storage; only written while enabled.
    always_ff @(posedge lmmi_clk_i) begin
        if (en_i && we)
            mem[wr_ptr] <= wentry;
    end

    // Pointers, level, channel counters, state and TX register.
    always_ff @(posedge lmmi_clk_i) begin
        if (!reset_n_i || !en_i) begin
            state     <= ST_PRIME;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            rx_ch     <= '0;
            tx_ch     <= '0;
            frame_acc <= 1'b0;
            tx_data_o <= '0;
        end else begin
            state     <= state_nxt;
            rd_ptr    <= rd_nxt;
            level     <= lvl_nxt;
            tx_data_o <= tx_nxt;
            if (we)
                wr_ptr <= inc(wr_ptr);
            if (rx_valid_i) begin
                rx_ch <= rx_last ? '0 : rx_ch + 1'b1;
                if (rx_first)
                    frame_acc <= accept;
            end
            if (tx_req_i)
                tx_ch <= tx_last ? '0 : tx_ch + 1'b1;
        end
    end

    // Sticky status; a set event in the same cycle beats clear_i.
    always_ff @(posedge lmmi_clk_i) begin
        if (!reset_n_i) begin
            overflow_o <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            if (en_i && drop_ev)
                overflow_o <= 1'b1;
            else if (clear_i)
                overflow_o <= 1'b0;
            if (en_i && underrun_ev)
                underrun_o <= 1'b1;
            else if (clear_i)
                underrun_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_frame_bridge.sv
// tb_i2s_frame_bridge: directed checks of priming, playback, overflow,
// underrun (zero and hold policies), simultaneous traffic and enable.
module tb_i2s_frame_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b1;
    logic        rx_valid = 1'b0;
    logic [31:0] rx_data = '0;
    logic        tx_req = 1'b0;
    logic        clr = 1'b0;

    logic [31:0] tx0, tx1;
    logic [4:0]  lvl0, lvl1;
    logic        run0, run1, ovf0, ovf1, und0, und1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    i2s_frame_bridge #(.UNDERRUN_HOLD(0)) dut0 (
        .lmmi_clk_i(clk), .reset_n_i(reset_n), .en_i(en),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .tx_req_i(tx_req), .tx_data_o(tx0), .clear_i(clr),
        .level_o(lvl0), .running_o(run0),
        .overflow_o(ovf0), .underrun_o(und0)
    );

    i2s_frame_bridge #(.UNDERRUN_HOLD(1)) dut1 (
        .lmmi_clk_i(clk), .reset_n_i(reset_n), .en_i(en),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .tx_req_i(tx_req), .tx_data_o(tx1), .clear_i(clr),
        .level_o(lvl1), .running_o(run1),
        .overflow_o(ovf1), .underrun_o(und1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        en = 1'b1;
        rx_valid = 1'b0;
        tx_req = 1'b0;
        clr = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic rx(input logic [31:0] d);
        rx_valid = 1'b1;
        rx_data = d;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic tx();
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({lvl0, run0, ovf0, und0, tx0} !== {5'd0, 3'b000, 32'd0})
            $display("FAIL reset dut0: lvl=%0d run=%b ovf=%b und=%b tx=%h",
                     lvl0, run0, ovf0, und0, tx0);
        else n_pass++;
        n_total++;
        if ({lvl1, run1, ovf1, und1, tx1} !== {5'd0, 3'b000, 32'd0})
            $display("FAIL reset dut1: lvl=%0d run=%b ovf=%b und=%b tx=%h",
                     lvl1, run1, ovf1, und1, tx1);
        else n_pass++;
    endtask

    task automatic test_prime_play();
        logic [31:0] exp_q [4];
        exp_q = '{32'h00000001, 32'hFF800000, 32'h00000002, 32'h00000003};
        do_reset();
        tx();
        rx(32'h000001);
        rx(32'h800000);
        n_total++;
        if (run0 !== 1'b0 || lvl0 !== 5'd2)
            $display("FAIL prime_one_frame: run=%b lvl=%0d want 0/2", run0, lvl0);
        else n_pass++;
        rx(32'h000002);
        rx(32'h000003);
        tick();
        n_total++;
        if (run0 !== 1'b0 || lvl0 !== 5'd4)
            $display("FAIL prime_wait_txch: run=%b lvl=%0d want 0/4", run0, lvl0);
        else n_pass++;
        tx();
        n_total++;
        if (run0 !== 1'b1)
            $display("FAIL prime_start: run=%b want 1", run0);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (tx0 !== exp_q[i])
                $display("FAIL play_%0d: tx=%h want %h", i, tx0, exp_q[i]);
            else n_pass++;
            tx();
        end
        n_total++;
        if (tx0 !== 32'd0 || lvl0 !== 5'd0 || und0 !== 1'b0)
            $display("FAIL play_empty: tx=%h lvl=%0d und=%b want 0/0/0",
                     tx0, lvl0, und0);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++)
            rx(32'h100 + i);
        n_total++;
        if (lvl0 !== 5'd16 || ovf0 !== 1'b0)
            $display("FAIL ovf_full: lvl=%0d ovf=%b want 16/0", lvl0, ovf0);
        else n_pass++;
        rx(32'h1F0);
        rx(32'h1F1);
        n_total++;
        if (lvl0 !== 5'd16 || ovf0 !== 1'b1)
            $display("FAIL ovf_drop: lvl=%0d ovf=%b want 16/1", lvl0, ovf0);
        else n_pass++;
        n_total++;
        if (tx0 !== 32'h100)
            $display("FAIL ovf_head: tx=%h want 00000100", tx0);
        else n_pass++;
        tx();
        tx();
        n_total++;
        if (lvl0 !== 5'd14 || tx0 !== 32'h102)
            $display("FAIL ovf_pop: lvl=%0d tx=%h want 14/00000102", lvl0, tx0);
        else n_pass++;
        rx(32'h200);
        rx(32'h201);
        n_total++;
        if (lvl0 !== 5'd16 || ovf0 !== 1'b1)
            $display("FAIL ovf_accept: lvl=%0d ovf=%b want 16/1", lvl0, ovf0);
        else n_pass++;
    endtask

    task automatic test_underrun_resync();
        do_reset();
        rx(32'h10);
        rx(32'h11);
        rx(32'h12);
        rx(32'h13);
        tick();
        rx(32'h14);
        for (int i = 0; i < 5; i++)
            tx();
        n_total++;
        if (lvl0 !== 5'd0 || run0 !== 1'b1 || und0 !== 1'b0)
            $display("FAIL und_drained: lvl=%0d run=%b und=%b want 0/1/0",
                     lvl0, run0, und0);
        else n_pass++;
        tx();
        n_total++;
        if (und0 !== 1'b1 || run0 !== 1'b0 || tx0 !== 32'd0)
            $display("FAIL und_event: und=%b run=%b tx=%h want 1/0/0",
                     und0, run0, tx0);
        else n_pass++;
        rx(32'h15);
        n_total++;
        if (lvl0 !== 5'd1)
            $display("FAIL und_orphan_in: lvl=%0d want 1", lvl0);
        else n_pass++;
        tick();
        n_total++;
        if (lvl0 !== 5'd0)
            $display("FAIL und_orphan_drop: lvl=%0d want 0", lvl0);
        else n_pass++;
        rx(32'h20);
        rx(32'h21);
        rx(32'h22);
        rx(32'h23);
        tick();
        n_total++;
        if (run0 !== 1'b1 || tx0 !== 32'h20 || und0 !== 1'b1)
            $display("FAIL und_restart: run=%b tx=%h und=%b want 1/00000020/1",
                     run0, tx0, und0);
        else n_pass++;
    endtask

    task automatic test_hold();
        do_reset();
        rx(32'h000001);
        rx(32'h000002);
        rx(32'h000003);
        rx(32'h123456);
        tick();
        for (int i = 0; i < 4; i++)
            tx();
        n_total++;
        if (tx1 !== 32'h00123456 || tx0 !== 32'd0)
            $display("FAIL hold_empty: tx1=%h tx0=%h want 00123456/0", tx1, tx0);
        else n_pass++;
        tx();
        tick();
        n_total++;
        if (tx1 !== 32'h00123456 || und1 !== 1'b1 || run1 !== 1'b0)
            $display("FAIL hold_underrun: tx1=%h und=%b run=%b want 00123456/1/0",
                     tx1, und1, run1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 6; i++)
            rx(32'hA0 + i);
        tx();
        n_total++;
        if (lvl0 !== 5'd5 || tx0 !== 32'hA1)
            $display("FAIL b2b_pre: lvl=%0d tx=%h want 5/000000a1", lvl0, tx0);
        else n_pass++;
        rx_valid = 1'b1;
        rx_data = 32'hA6;
        tx_req = 1'b1;
        tick();
        rx_valid = 1'b0;
        tx_req = 1'b0;
        n_total++;
        if (lvl0 !== 5'd5 || tx0 !== 32'hA2)
            $display("FAIL b2b_same: lvl=%0d tx=%h want 5/000000a2", lvl0, tx0);
        else n_pass++;
        rx(32'hA7);
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (tx0 !== 32'hA2 + i)
                $display("FAIL b2b_order_%0d: tx=%h want %h", i, tx0, 32'hA2 + i);
            else n_pass++;
            tx();
        end
        n_total++;
        if (lvl0 !== 5'd0)
            $display("FAIL b2b_end: lvl=%0d want 0", lvl0);
        else n_pass++;
    endtask

    task automatic test_enable_clear();
        do_reset();
        for (int i = 0; i < 18; i++)
            rx(32'h300 + i);
        n_total++;
        if (ovf0 !== 1'b1 || tx0 !== 32'h300 || run0 !== 1'b1)
            $display("FAIL en_pre: ovf=%b tx=%h run=%b want 1/00000300/1",
                     ovf0, tx0, run0);
        else n_pass++;
        en = 1'b0;
        tick();
        n_total++;
        if (lvl0 !== 5'd0 || tx0 !== 32'd0 || run0 !== 1'b0 || ovf0 !== 1'b1)
            $display("FAIL en_low: lvl=%0d tx=%h run=%b ovf=%b want 0/0/0/1",
                     lvl0, tx0, run0, ovf0);
        else n_pass++;
        en = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_total++;
        if (ovf0 !== 1'b0 || und0 !== 1'b0 || ovf1 !== 1'b0)
            $display("FAIL clear: ovf=%b und=%b ovf1=%b want 0/0/0",
                     ovf0, und0, ovf1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_prime_play();
        test_overflow();
        test_underrun_resync();
        test_hold();
        test_back_to_back();
        test_enable_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
